// File: rtl/cpu_program_feeder_if.sv
// Bundle between the program feeder and its neighbours: load port, CPU-facing bus and run status.
interface cpu_program_feeder_if #(
    parameter int unsigned AW = 5
) ();
    logic          load_valid;
    logic [7:0]    load_data;
    logic          load_ready;
    logic          go;
    logic          clear;
    logic [7:0]    cpu_status;
    logic [7:0]    cpu_result;
    logic [7:0]    cpu_instr;
    logic          result_valid;
    logic [7:0]    result_data;
    logic [AW:0]   prog_len;
    logic          busy;
    logic          done;
    logic          sync_err;

    modport slave (
        input  load_valid, load_data, go, clear, cpu_status, cpu_result,
        output load_ready, cpu_instr, result_valid, result_data, prog_len, busy, done, sync_err
    );

    modport master (
        output load_valid, load_data, go, clear, cpu_status, cpu_result,
        input  load_ready, cpu_instr, result_valid, result_data, prog_len, busy, done, sync_err
    );
endinterface

// File: rtl/cpu_program_feeder.sv
// Program-side responder for the 8-bit CPU: buffers a loaded program, serves opcode/immediate
// bytes in step with the CPU state bus, and captures the CPU result after each writeback.
module cpu_program_feeder #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    cpu_program_feeder_if.slave   bus
);
    localparam int unsigned DW = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] CPU_F  = 2'b00;
    localparam logic [1:0] CPU_D  = 2'b01;
    localparam logic [1:0] CPU_WB = 2'b11;

    logic [DW-1:0] mem_q [DEPTH];

    logic [1:0]    state_q,   state_d;
    logic [AW:0]   wptr_q,    wptr_d;
    logic [AW:0]   rptr_q,    rptr_d;
    logic [1:0]    prev_st_q, prev_st_d;
    logic          pend_q,    pend_d;
    logic          rvalid_q,  rvalid_d;
    logic [DW-1:0] rdata_q,   rdata_d;
    logic          serr_q,    serr_d;

    logic          mem_we_c;
    logic          load_ready_c;
    logic [DW-1:0] instr_c;
    logic [1:0]    st_c;
    logic [AW+1:0] rptr_nx2_c;
    logic          unused_pc_c;

    // Bytes at or beyond the loaded length read as zero.
    function automatic logic [DW-1:0] rd_byte(input logic [AW:0] addr);
        if (addr < wptr_q) return mem_q[addr[AW-1:0]];
        return '0;
    endfunction

    assign st_c        = bus.cpu_status[1:0];
    assign unused_pc_c = ^bus.cpu_status[7:2];
    assign rptr_nx2_c  = (AW+2)'(rptr_q) + (AW+2)'(2);

    always_comb begin
        state_d      = state_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        prev_st_d    = st_c;
        pend_d       = 1'b0;
        rvalid_d     = pend_q;
        rdata_d      = pend_q ? bus.cpu_result : rdata_q;
        serr_d       = serr_q;
        mem_we_c     = 1'b0;
        instr_c      = '0;
        load_ready_c = (state_q == S_IDLE) && (wptr_q < (AW+1)'(DEPTH));

        case (state_q)
            S_IDLE: begin
                if (bus.load_valid && load_ready_c) begin
                    mem_we_c = 1'b1;
                    wptr_d   = wptr_q + (AW+1)'(1);
                end
                if (bus.go && ((wptr_q != '0) || mem_we_c)) begin
                    state_d = S_ARM;
                    rptr_d  = '0;
                end
            end
            S_ARM: begin
                // The first observed FETCH is served here and becomes the first RUN step.
                if (st_c == CPU_F) begin
                    instr_c = rd_byte(rptr_q);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                case (st_c)
                    CPU_F:   instr_c = rd_byte(rptr_q);
                    CPU_D:   instr_c = rd_byte(rptr_q + (AW+1)'(1));
                    default: instr_c = '0;
                endcase
                if (st_c != 2'(prev_st_q + 2'd1)) begin
                    serr_d  = 1'b1;
                    state_d = S_DONE;
                end else if (st_c == CPU_WB) begin
                    rptr_d = rptr_q + (AW+1)'(2);
                    pend_d = 1'b1;
                    if (rptr_nx2_c >= (AW+2)'(wptr_q)) state_d = S_DONE;
                end
            end
            default: ;
        endcase

        if (bus.clear) begin
            state_d  = S_IDLE;
            wptr_d   = '0;
            rptr_d   = '0;
            serr_d   = 1'b0;
            pend_d   = 1'b0;
            rvalid_d = 1'b0;
            rdata_d  = rdata_q;
            mem_we_c = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wptr_q    <= '0;
            rptr_q    <= '0;
            prev_st_q <= '0;
            pend_q    <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            serr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            prev_st_q <= prev_st_d;
            pend_q    <= pend_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            serr_q    <= serr_d;
        end
    end

    // Program buffer has no reset; unloaded locations are masked by rd_byte.
    always_ff @(posedge clk) begin
        if (mem_we_c && !rst) mem_q[wptr_q[AW-1:0]] <= bus.load_data;
    end

    assign bus.load_ready   = load_ready_c;
    assign bus.cpu_instr    = instr_c;
    assign bus.result_valid = rvalid_q;
    assign bus.result_data  = rdata_q;
    assign bus.prog_len     = wptr_q;
    assign bus.busy         = (state_q == S_ARM) || (state_q == S_RUN);
    assign bus.done         = (state_q == S_DONE);
    assign bus.sync_err     = serr_q;
endmodule

// File: tb/tb_cpu_program_feeder.sv
// Scoreboard bench for cpu_program_feeder: stimulus queues expected bytes/results, a monitor checks them.
module tb_cpu_program_feeder;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = 5;
    localparam logic [1:0] F = 2'b00, D = 2'b01, E = 2'b10, WB = 2'b11;

    logic clk = 1'b0;
    logic rst;
    cpu_program_feeder_if #(.AW(AW)) bus ();

    cpu_program_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] instr_q [$];
    logic [7:0] res_q   [$];
    logic       chk_instr = 1'b0;
    logic       last_wb   = 1'b0;
    logic [7:0] next_res  = 8'h3C;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One CPU state cycle; cpu_result carries next_res only in the cycle after a WB.
    task automatic cpu_cycle(input logic [1:0] st, input logic [7:0] exp, input bit push_res);
        bus.cpu_status = {6'd0, st};
        bus.cpu_result = last_wb ? next_res : 8'hEE;
        instr_q.push_back(exp);
        if (push_res) res_q.push_back(next_res);
        chk_instr = 1'b1;
        step();
        chk_instr = 1'b0;
        bus.cpu_result = 8'hEE;
        last_wb = (st == WB);
    endtask

    task automatic load_bytes(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3, input int n);
        logic [7:0] bytes [4];
        bytes = '{b0, b1, b2, b3};
        for (int i = 0; i < n; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = bytes[i];
            step();
        end
        bus.load_valid = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
    endtask

    // Monitor: mid-cycle, compare served byte and any result pulse against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (chk_instr) begin
                if (instr_q.size() == 0) chk("instr_queue", 32'd1, 32'd0);
                else chk("cpu_instr", 32'(bus.cpu_instr), 32'(instr_q.pop_front()));
            end
            if (bus.result_valid) begin
                if (res_q.size() == 0) chk("unexpected_result_valid", 32'd1, 32'd0);
                else chk("result_data", 32'(bus.result_data), 32'(res_q.pop_front()));
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.load_valid = 1'b0;
        bus.load_data  = 8'h00;
        bus.go         = 1'b0;
        bus.clear      = 1'b0;
        bus.cpu_status = 8'h00;
        bus.cpu_result = 8'hEE;
        step();
        step();
        chk("rst_prog_len", 32'(bus.prog_len), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_sync_err", 32'(bus.sync_err), 32'd0);
        chk("rst_result_valid", 32'(bus.result_valid), 32'd0);
        chk("rst_result_data", 32'(bus.result_data), 32'd0);
        chk("rst_cpu_instr", 32'(bus.cpu_instr), 32'd0);
        rst = 1'b0;
        bus.cpu_status = {6'd0, E};
        step();
        chk("idle_load_ready", 32'(bus.load_ready), 32'd1);

        // 1-3) basic load, go, run, results
        load_bytes(8'h11, 8'hA5, 8'h22, 8'h5A, 4);
        chk("t1_prog_len", 32'(bus.prog_len), 32'd4);
        chk("t1_load_ready", 32'(bus.load_ready), 32'd1);
        bus.go = 1'b1;
        cpu_cycle(E, 8'h00, 1'b0);
        bus.go = 1'b0;
        chk("t1_busy", 32'(bus.busy), 32'd1);
        next_res = 8'h3C;
        cpu_cycle(F, 8'h11, 1'b0);
        cpu_cycle(D, 8'hA5, 1'b0);
        cpu_cycle(E, 8'h00, 1'b0);
        cpu_cycle(WB, 8'h00, 1'b1);
        chk("t2_done_mid", 32'(bus.done), 32'd0);
        cpu_cycle(F, 8'h22, 1'b0);
        cpu_cycle(D, 8'h5A, 1'b0);
        cpu_cycle(E, 8'h00, 1'b0);
        cpu_cycle(WB, 8'h00, 1'b1);
        chk("t2_done", 32'(bus.done), 32'd1);
        chk("t2_busy", 32'(bus.busy), 32'd0);
        cpu_cycle(F, 8'h00, 1'b0);
        step();
        step();

        // 4) full buffer: DEPTH+3 writes, extras must not land
        do_clear();
        chk("t4_clr_prog_len", 32'(bus.prog_len), 32'd0);
        for (int i = 0; i < DEPTH + 3; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = (i < DEPTH) ? 8'(i + 1) : 8'(8'hF0 + i);
            step();
        end
        bus.load_valid = 1'b0;
        chk("t4_load_ready", 32'(bus.load_ready), 32'd0);
        chk("t4_prog_len", 32'(bus.prog_len), 32'(DEPTH));
        bus.go = 1'b1;
        cpu_cycle(E, 8'h00, 1'b0);
        bus.go = 1'b0;
        next_res = 8'h77;
        for (int j = 0; j < DEPTH / 2; j++) begin
            cpu_cycle(F, 8'(2 * j + 1), 1'b0);
            cpu_cycle(D, 8'(2 * j + 2), 1'b0);
            cpu_cycle(E, 8'h00, 1'b0);
            cpu_cycle(WB, 8'h00, 1'b1);
        end
        chk("t4_done", 32'(bus.done), 32'd1);
        cpu_cycle(F, 8'h00, 1'b0);
        step();

        // 5) sync error
        do_clear();
        load_bytes(8'h11, 8'hA5, 8'h22, 8'h5A, 4);
        bus.go = 1'b1;
        cpu_cycle(E, 8'h00, 1'b0);
        bus.go = 1'b0;
        cpu_cycle(F, 8'h11, 1'b0);
        cpu_cycle(D, 8'hA5, 1'b0);
        cpu_cycle(WB, 8'h00, 1'b0);
        chk("t5_sync_err", 32'(bus.sync_err), 32'd1);
        chk("t5_done", 32'(bus.done), 32'd1);
        cpu_cycle(F, 8'h00, 1'b0);
        step();
        do_clear();
        chk("t5_clr_sync_err", 32'(bus.sync_err), 32'd0);
        chk("t5_clr_done", 32'(bus.done), 32'd0);
        chk("t5_clr_ready", 32'(bus.load_ready), 32'd1);

        // 6) ARM waits for FETCH; odd length serves 0x00 for the last immediate
        load_bytes(8'h31, 8'h32, 8'h33, 8'h00, 3);
        chk("t6_prog_len", 32'(bus.prog_len), 32'd3);
        bus.go = 1'b1;
        cpu_cycle(E, 8'h00, 1'b0);
        bus.go = 1'b0;
        cpu_cycle(E, 8'h00, 1'b0);
        cpu_cycle(WB, 8'h00, 1'b0);
        cpu_cycle(D, 8'h00, 1'b0);
        chk("t6_arm_busy", 32'(bus.busy), 32'd1);
        next_res = 8'h3C;
        cpu_cycle(F, 8'h31, 1'b0);
        cpu_cycle(D, 8'h32, 1'b0);
        cpu_cycle(E, 8'h00, 1'b0);
        cpu_cycle(WB, 8'h00, 1'b1);
        cpu_cycle(F, 8'h33, 1'b0);
        cpu_cycle(D, 8'h00, 1'b0);
        cpu_cycle(E, 8'h00, 1'b0);
        cpu_cycle(WB, 8'h00, 1'b1);
        chk("t6_done", 32'(bus.done), 32'd1);
        chk("t6_sync_err", 32'(bus.sync_err), 32'd0);
        cpu_cycle(F, 8'h00, 1'b0);
        step();

        // reset mid-RUN drops the pending result
        do_clear();
        load_bytes(8'h41, 8'h42, 8'h00, 8'h00, 2);
        bus.go = 1'b1;
        cpu_cycle(E, 8'h00, 1'b0);
        bus.go = 1'b0;
        cpu_cycle(F, 8'h41, 1'b0);
        cpu_cycle(D, 8'h42, 1'b0);
        cpu_cycle(E, 8'h00, 1'b0);
        cpu_cycle(WB, 8'h00, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_run_prog_len", 32'(bus.prog_len), 32'd0);
        chk("rst_run_busy", 32'(bus.busy), 32'd0);
        chk("rst_run_result_valid", 32'(bus.result_valid), 32'd0);

        // go with an empty buffer is ignored
        bus.go = 1'b1;
        step();
        bus.go = 1'b0;
        chk("go_empty_busy", 32'(bus.busy), 32'd0);
        chk("go_empty_ready", 32'(bus.load_ready), 32'd1);
        step();
        step();
        chk("results_outstanding", 32'(res_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
